// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the dmem arbiter.
package dmem_arb_pkg;

  localparam int unsigned DMEM_ADDR_W = 12;
  localparam int unsigned DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    P    = 2'd1,
    X    = 2'd2
  } rd_owner_t;

endpackage

// File: rtl/dmem_arb_starve.sv
// Starvation guard for port X: counts cycles X waits and flags when it must go first.
module dmem_arb_starve #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic x_req,
  input  logic x_gnt,
  output logic starve
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

  logic [7:0] wait_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!x_req || x_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != MAX_CNT) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign starve = (wait_cnt == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter (P priority) for the single-port dmem with read-return routing.
// Define DMEM_ARB_STARVE_GUARD_EN to build the X starvation guard.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   p_req,
  input  logic                   p_wren,
  input  logic [DMEM_ADDR_W-1:0] p_addr,
  input  logic [DMEM_DATA_W-1:0] p_data,
  input  logic                   x_req,
  input  logic                   x_wren,
  input  logic [DMEM_ADDR_W-1:0] x_addr,
  input  logic [DMEM_DATA_W-1:0] x_data,
  output logic                   p_gnt,
  output logic                   x_gnt,
  output logic                   p_rvalid,
  output logic                   x_rvalid,
  output logic [DMEM_DATA_W-1:0] p_q,
  output logic [DMEM_DATA_W-1:0] x_q,
  output logic [DMEM_ADDR_W-1:0] address_dmem,
  output logic [DMEM_DATA_W-1:0] data,
  output logic                   wren,
  input  logic [DMEM_DATA_W-1:0] q_dmem
);

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("dmem_arbiter: MAX_WAIT out of range 1..255");
  end

  logic      starve;
  rd_owner_t rd_owner;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  dmem_arb_starve #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clock  (clock),
    .reset  (reset),
    .x_req  (x_req),
    .x_gnt  (x_gnt),
    .starve (starve)
  );
`else
  assign starve = 1'b0;
`endif

  // Grants are suppressed while reset is high so dmem sees no access.
  always_comb begin
    p_gnt        = 1'b0;
    x_gnt        = 1'b0;
    address_dmem = '0;
    data         = '0;
    wren         = 1'b0;
    if (!reset) begin
      if (p_req && !(starve && x_req)) begin
        p_gnt = 1'b1;
      end else if (x_req) begin
        x_gnt = 1'b1;
      end
    end
    if (p_gnt) begin
      address_dmem = p_addr;
      data         = p_data;
      wren         = p_wren;
    end else if (x_gnt) begin
      address_dmem = x_addr;
      data         = x_data;
      wren         = x_wren;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_owner <= NONE;
    end else if (p_gnt && !p_wren) begin
      rd_owner <= P;
    end else if (x_gnt && !x_wren) begin
      rd_owner <= X;
    end else begin
      rd_owner <= NONE;
    end
  end

  assign p_rvalid = (rd_owner == P);
  assign x_rvalid = (rd_owner == X);
  assign p_q      = p_rvalid ? q_dmem : '0;
  assign x_q      = x_rvalid ? q_dmem : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model and a behavioural dmem.
module tb_dmem_arbiter;

  localparam int unsigned MAXW = 8;
`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        p_req, p_wren, x_req, x_wren;
  logic [11:0] p_addr, x_addr;
  logic [31:0] p_data, x_data;
  logic        p_gnt, x_gnt, p_rvalid, x_rvalid;
  logic [31:0] p_q, x_q;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;

  dmem_arbiter #(.MAX_WAIT(MAXW)) dut (
    .clock(clock), .reset(reset),
    .p_req(p_req), .p_wren(p_wren), .p_addr(p_addr), .p_data(p_data),
    .x_req(x_req), .x_wren(x_wren), .x_addr(x_addr), .x_data(x_data),
    .p_gnt(p_gnt), .x_gnt(x_gnt), .p_rvalid(p_rvalid), .x_rvalid(x_rvalid),
    .p_q(p_q), .x_q(x_q), .address_dmem(address_dmem), .data(data),
    .wren(wren), .q_dmem(q_dmem)
  );

  always #5 clock = ~clock;

  // Behavioural single-port synchronous memory.
  logic [31:0] mem [4096];
  always @(posedge clock) begin
    if (wren) mem[address_dmem] <= data;
    q_dmem <= mem[address_dmem];
  end

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] ref_mem [4096];
  int          m_owner;      // 0 none, 1 P, 2 X
  logic [31:0] m_rdata;
  int unsigned m_wait;
  logic        e_pg, e_xg, e_wren;
  logic [11:0] e_addr;
  logic [31:0] e_data;
  // Mid-cycle samples of DUT outputs for directed checks
  logic        s_pgnt, s_xgnt, s_prv, s_xrv;
  logic [31:0] s_pq, s_xq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check all outputs mid-cycle, then advance the model at the edge.
  task automatic cycle(input bit rst_at_edge);
    bit starve;
    @(negedge clock);
    starve = GUARD && (m_wait == MAXW);
    e_pg = 1'b0; e_xg = 1'b0;
    if (!reset) begin
      e_pg = p_req && !(starve && x_req);
      e_xg = x_req && !e_pg;
    end
    e_addr = e_pg ? p_addr : (e_xg ? x_addr : 12'd0);
    e_data = e_pg ? p_data : (e_xg ? x_data : 32'd0);
    e_wren = e_pg ? p_wren : (e_xg ? x_wren : 1'b0);
    chk("p_gnt", 32'(p_gnt), 32'(e_pg));
    chk("x_gnt", 32'(x_gnt), 32'(e_xg));
    chk("address_dmem", 32'(address_dmem), 32'(e_addr));
    chk("data", data, e_data);
    chk("wren", 32'(wren), 32'(e_wren));
    chk("p_rvalid", 32'(p_rvalid), 32'(m_owner == 1));
    chk("x_rvalid", 32'(x_rvalid), 32'(m_owner == 2));
    chk("p_q", p_q, (m_owner == 1) ? m_rdata : 32'd0);
    chk("x_q", x_q, (m_owner == 2) ? m_rdata : 32'd0);
    s_pgnt = p_gnt; s_xgnt = x_gnt; s_prv = p_rvalid; s_xrv = x_rvalid;
    s_pq = p_q; s_xq = x_q;
    @(posedge clock);
    if (rst_at_edge) reset = 1'b1;
    if (reset) begin
      m_owner = 0;
      m_wait  = 0;
    end else begin
      m_owner = 0;
      if ((e_pg || e_xg) && !e_wren) begin
        m_owner = e_pg ? 1 : 2;
        m_rdata = ref_mem[e_addr];
      end
      if ((e_pg || e_xg) && e_wren) ref_mem[e_addr] = e_data;
      if (x_req && !e_xg) m_wait = (m_wait + 1 > MAXW) ? MAXW : m_wait + 1;
      else m_wait = 0;
    end
    #1;
  endtask

  task automatic set_p(input logic req, input logic wr, input logic [11:0] a, input logic [31:0] d);
    p_req = req; p_wren = wr; p_addr = a; p_data = d;
  endtask

  task automatic set_x(input logic req, input logic wr, input logic [11:0] a, input logic [31:0] d);
    x_req = req; x_wren = wr; x_addr = a; x_data = d;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 32'(i) ^ 32'hA5A5_0000;
      ref_mem[i] = 32'(i) ^ 32'hA5A5_0000;
    end
    mem[16] = 32'hDEADBEEF;
    ref_mem[16] = 32'hDEADBEEF;
    m_owner = 0; m_rdata = '0; m_wait = 0;

    // Reset held with both requesters active: everything must stay 0.
    reset = 1'b1;
    set_p(1, 0, 12'h123, 32'h1111_1111);
    set_x(1, 1, 12'h456, 32'h2222_2222);
    cycle(0);
    chk("rst_p_gnt", 32'(s_pgnt), 0);
    chk("rst_x_gnt", 32'(s_xgnt), 0);
    reset = 1'b0;
    set_p(0, 0, 0, 0); set_x(0, 0, 0, 0);
    cycle(0);

    // P read of preloaded word.
    set_p(1, 0, 12'h010, 0);
    cycle(0);
    chk("pread_gnt", 32'(s_pgnt), 1);
    set_p(0, 0, 0, 0);
    cycle(0);
    chk("pread_rvalid", 32'(s_prv), 1);
    chk("pread_q", s_pq, 32'hDEADBEEF);
    chk("pread_x_rvalid", 32'(s_xrv), 0);
    cycle(0);
    chk("pread_x_rvalid_after", 32'(s_xrv), 0);

    // P write then X read of the same address.
    set_p(1, 1, 12'h0A0, 32'h12345678);
    cycle(0);
    chk("pwr_gnt", 32'(s_pgnt), 1);
    set_p(0, 0, 0, 0);
    set_x(1, 0, 12'h0A0, 0);
    cycle(0);
    chk("xrd_gnt", 32'(s_xgnt), 1);
    set_x(0, 0, 0, 0);
    cycle(0);
    chk("xrd_rvalid", 32'(s_xrv), 1);
    chk("xrd_q", s_xq, 32'h12345678);

    // Both requesters held for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      set_p(1, 0, 12'(i), 0);
      set_x(1, 0, 12'h200 + 12'(i), 0);
      cycle(0);
      chk($sformatf("hold_x_gnt_%0d", i), 32'(s_xgnt), 32'(GUARD && (i == 8 || i == 17)));
      chk($sformatf("hold_p_gnt_%0d", i), 32'(s_pgnt), 32'(!(GUARD && (i == 8 || i == 17))));
    end
    set_p(0, 0, 0, 0); set_x(0, 0, 0, 0);
    cycle(0);

    // Alternating P/X reads: rvalid follows one cycle behind each grant.
    for (int i = 0; i < 7; i++) begin
      set_p(i < 6 && i % 2 == 0, 0, 12'h300 + 12'(i), 0);
      set_x(i < 6 && i % 2 == 1, 0, 12'h300 + 12'(i), 0);
      cycle(0);
      if (i > 0) begin
        chk($sformatf("alt_p_rvalid_%0d", i), 32'(s_prv), 32'((i - 1) % 2 == 0));
        chk($sformatf("alt_x_rvalid_%0d", i), 32'(s_xrv), 32'((i - 1) % 2 == 1));
      end
      chk($sformatf("alt_not_both_%0d", i), 32'(s_prv && s_xrv), 0);
    end
    set_p(0, 0, 0, 0); set_x(0, 0, 0, 0);

    // X read granted, reset arrives on the following edge.
    set_x(1, 0, 12'h010, 0);
    cycle(1);
    chk("rstmid_x_gnt", 32'(s_xgnt), 1);
    cycle(0);
    chk("rstmid_x_rvalid_t1", 32'(s_xrv), 0);
    chk("rstmid_x_gnt_t1", 32'(s_xgnt), 0);
    chk("rstmid_x_q_t1", s_xq, 0);
    reset = 1'b0;
    set_x(0, 0, 0, 0);
    cycle(0);
    chk("rstmid_x_rvalid_t2", 32'(s_xrv), 0);

    // Randomized traffic; requests held until granted, X may occasionally give up.
    for (int i = 0; i < 400; i++) begin
      if (!(p_req && !e_pg))
        set_p(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), $urandom);
      if (x_req && !e_xg) begin
        if ($urandom_range(0, 15) == 0) x_req = 1'b0;
      end else begin
        set_x(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), $urandom);
      end
      cycle(0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
